result_serializer: RTL

- Downstream stage of the matrix multiplier: captures the 9-element × 16-bit product when multiplication completes, then streams it to the UART transmitter as 18 bytes.
- Replaces the ad-hoc result_byte/result_index logic in the top level with a proper start/busy handshake.
- Sits between the Calculator (mult_result, mult_done) and uart_tx (data, start, busy). All logic runs on the baud-derived clock.

---
 rtl/result_serializer_pkg.sv | 35 +++
 rtl/result_serializer_tx_handshake.sv | 69 ++++++
 rtl/result_serializer.sv | 115 +++++++++++
 3 files changed

// File: rtl/result_serializer_pkg.sv
// Shared types and sizing for the result serializer and its byte handshake.
package result_serializer_pkg;

   localparam int unsigned N_ELEM_DEF      = 9;
   localparam int unsigned ELEM_W_DEF      = 16;
   localparam int unsigned ACK_TIMEOUT_DEF = 16;

   localparam int unsigned BYTES_PER_ELEM = ELEM_W_DEF / 8;
   localparam int unsigned TOTAL_BYTES    = N_ELEM_DEF * BYTES_PER_ELEM;

   // Serializer states; the handshake uses WaitIdle..WaitDone, the top uses Idle/Send/Next.
   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWaitIdle = 3'd1,
      StSend     = 3'd2,
      StWaitAck  = 3'd3,
      StWaitDone = 3'd4,
      StNext     = 3'd5
   } ser_state_t;

   // Board-level sequencer states, shared so the top level and this block agree.
   typedef enum logic [2:0] {
      TopIdle       = 3'd0,
      TopRecvA      = 3'd1,
      TopRecvB      = 3'd2,
      TopCalc       = 3'd3,
      TopSendResult = 3'd4
   } top_state_t;

   function automatic int unsigned total_bytes(input int unsigned n_elem,
                                               input int unsigned elem_w);
      return n_elem * (elem_w / 8);
   endfunction

endpackage

// File: rtl/result_serializer_tx_handshake.sv
// One-byte start/busy handshake towards uart_tx, with a timeout on the busy acknowledge.
module result_serializer_tx_handshake
   import result_serializer_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_req,
   input  logic [7:0] byte_in,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       byte_done,
   output logic       timeout
);

   localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

   ser_state_t       state;
   logic [CNT_W-1:0] ack_cnt;

   // Completion and abort strobes are combinational so the owner reacts on the same edge.
   assign byte_done = (state == StWaitDone) && !tx_busy;
   assign timeout   = (state == StWaitAck) && !tx_busy && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

   // Handshake sequencing with registered tx_start/tx_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         ack_cnt  <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         tx_start <= 1'b0;
         case (state)
            StIdle: begin
               if (byte_req) state <= StWaitIdle;
            end
            StWaitIdle: begin
               if (!tx_busy) begin
                  state    <= StSend;
                  tx_start <= 1'b1;
                  tx_data  <= byte_in;
                  ack_cnt  <= '0;
               end
            end
            StSend: begin
               state <= StWaitAck;
            end
            StWaitAck: begin
               if (tx_busy) begin
                  state <= StWaitDone;
               end else if (timeout) begin
                  state   <= StIdle;
                  ack_cnt <= '0;
               end else begin
                  ack_cnt <= ack_cnt + CNT_W'(1);
               end
            end
            StWaitDone: begin
               if (!tx_busy) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: rtl/result_serializer.sv
// Captures the multiplier result on load and streams it MS-byte-first, element 0 first.
module result_serializer
   import result_serializer_pkg::*;
#(
   parameter int unsigned N_ELEM      = N_ELEM_DEF,
   parameter int unsigned ELEM_W      = ELEM_W_DEF,
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [N_ELEM*ELEM_W-1:0] result,
   input  logic                     tx_busy,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   output logic                     active,
   output logic                     done,
   output logic                     load_err,
   output logic                     ack_err
);

   localparam int unsigned BPE    = ELEM_W / 8;
   localparam int unsigned NBYTES = total_bytes(N_ELEM, ELEM_W);
   localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   ser_state_t               state;
   logic [IDX_W-1:0]         byte_idx;
   logic [N_ELEM*ELEM_W-1:0] cap;
   logic [7:0]               byte_sel;
   logic                     accept;
   logic                     last;
   logic                     byte_req;
   logic                     byte_done;
   logic                     timeout;

   assign accept   = (state == StIdle) && load;
   assign last     = (byte_idx == LAST_IDX);
   assign byte_req = accept || ((state == StNext) && !last);

   // Result snapshot; intentionally not cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst && accept) cap <= result;
   end

   // Byte b comes from element b/BPE, MS byte first within the element.
   always_comb begin
      byte_sel = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         if (byte_idx == IDX_W'(i)) begin
            byte_sel = cap[(i / BPE) * ELEM_W + (BPE - 1 - (i % BPE)) * 8 +: 8];
         end
      end
   end

   // Transfer control; StSend spans the whole handshake for the current byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         byte_idx <= '0;
         active   <= 1'b0;
         done     <= 1'b0;
         load_err <= 1'b0;
         ack_err  <= 1'b0;
      end else begin
         done     <= 1'b0;
         load_err <= load && (state != StIdle);
         case (state)
            StIdle: begin
               if (load) begin
                  byte_idx <= '0;
                  active   <= 1'b1;
                  ack_err  <= 1'b0;
                  state    <= StSend;
               end
            end
            StSend: begin
               if (byte_done) begin
                  state <= StNext;
                  if (last) done <= 1'b1;
               end else if (timeout) begin
                  ack_err <= 1'b1;
                  active  <= 1'b0;
                  state   <= StIdle;
               end
            end
            StNext: begin
               if (last) begin
                  active <= 1'b0;
                  state  <= StIdle;
               end else begin
                  byte_idx <= byte_idx + IDX_W'(1);
                  state    <= StSend;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   result_serializer_tx_handshake #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_tx_handshake (
      .clk       (clk),
      .rst       (rst),
      .byte_req  (byte_req),
      .byte_in   (byte_sel),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .byte_done (byte_done),
      .timeout   (timeout)
   );

endmodule
